mem_access_unit: RTL and testbench

MEM-stage data-memory access unit. It is the write/narrow and read/extend counterpart of the immediate extender.
- Stores: narrows 32-bit register data onto byte lanes and generates byte enables.
- Loads: extracts the addressed byte or half from the returned word, then zero- or sign-extends it.
- Sits between the MEM pipeline register and a wait-stated valid/ready data bus, and stalls the pipeline until each access completes.

---
 rtl/mem_access_unit_pkg.sv | 35 +++
 rtl/mem_access_unit_data_lane_ext.sv | 37 +++
 rtl/mem_access_unit.sv | 158 +++++++++++++++
 tb/tb_mem_access_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data-memory access unit: access kinds, FSM states and
// small decode helpers used by the top level.
package mem_access_unit_pkg;

   localparam int DMOP_SIZE = 3;

   localparam logic [DMOP_SIZE-1:0] DMOP_BYTE  = 3'd0;
   localparam logic [DMOP_SIZE-1:0] DMOP_BYTEU = 3'd1;
   localparam logic [DMOP_SIZE-1:0] DMOP_HALF  = 3'd2;
   localparam logic [DMOP_SIZE-1:0] DMOP_HALFU = 3'd3;
   localparam logic [DMOP_SIZE-1:0] DMOP_WORD  = 3'd4;

   localparam logic [1:0] MAU_IDLE   = 2'd0;
   localparam logic [1:0] MAU_ISSUE  = 2'd1;
   localparam logic [1:0] MAU_WAIT_R = 2'd2;
   localparam logic [1:0] MAU_RESP   = 2'd3;

   // Unrecognised encodings behave as full-word accesses.
   function automatic logic [DMOP_SIZE-1:0] dmop_norm(input logic [DMOP_SIZE-1:0] op);
      if (op > DMOP_WORD) begin
         return DMOP_WORD;
      end
      return op;
   endfunction

   function automatic logic dmop_misaligned(input logic [DMOP_SIZE-1:0] op,
                                            input logic [1:0] lo);
      case (dmop_norm(op))
         DMOP_HALF, DMOP_HALFU: return lo[0];
         DMOP_WORD:             return lo != 2'b00;
         default:               return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_data_lane_ext.sv
// data_lane_ext: selects the addressed byte/half lane of a returned bus word and
// zero- or sign-extends it to 32 bits. Purely combinational.
module mem_access_unit_data_lane_ext
   import mem_access_unit_pkg::*;
(
   input  logic [DMOP_SIZE-1:0] op_i,
   input  logic [1:0]           addr_lo_i,
   input  logic [31:0]          word_i,
   output logic [31:0]          data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[7:0];
      case (addr_lo_i)
         2'd0:    byte_sel = word_i[7:0];
         2'd1:    byte_sel = word_i[15:8];
         2'd2:    byte_sel = word_i[23:16];
         default: byte_sel = word_i[31:24];
      endcase
      half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
   end

   always_comb begin
      data_o = word_i;
      case (op_i)
         DMOP_BYTE:  data_o = {{24{byte_sel[7]}}, byte_sel};
         DMOP_BYTEU: data_o = {24'h000000, byte_sel};
         DMOP_HALF:  data_o = {{16{half_sel[15]}}, half_sel};
         DMOP_HALFU: data_o = {16'h0000, half_sel};
         default:    data_o = word_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: store lane narrowing, load extension and a
// valid/ready bus FSM that stalls the pipeline. Build option ALIGN_CHECK_EN retires
// misaligned half/word accesses with resp_err and no bus cycle.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned BUS_AW = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [DMOP_SIZE-1:0] req_op,
   input  logic [31:0]          req_addr,
   input  logic [31:0]          req_wdata,
   output logic                 resp_valid,
   output logic [31:0]          resp_rdata,
   output logic                 resp_err,
   output logic                 stall,
   output logic                 bus_valid,
   input  logic                 bus_ready,
   output logic                 bus_we,
   output logic [BUS_AW-1:0]    bus_addr,
   output logic [3:0]           bus_be,
   output logic [31:0]          bus_wdata,
   input  logic                 bus_rvalid,
   input  logic [31:0]          bus_rdata
);

   logic [1:0]           state_q, state_d;
   logic                 write_q, write_d;
   logic [DMOP_SIZE-1:0] op_q, op_d;
   logic [31:0]          addr_q, addr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [31:0]          rdata_q, rdata_d;
   logic [31:0]          ext_data;
   logic [3:0]           st_be;
   logic [31:0]          st_wdata;
   logic                 in_issue;
`ifdef ALIGN_CHECK_EN
   logic                 err_q, err_d;
`endif

   mem_access_unit_data_lane_ext u_lane_ext (
      .op_i      (op_q),
      .addr_lo_i (addr_q[1:0]),
      .word_i    (bus_rdata),
      .data_o    (ext_data)
   );

   always_comb begin
      state_d = state_q;
      write_d = write_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
`ifdef ALIGN_CHECK_EN
      err_d   = err_q;
`endif
      case (state_q)
         MAU_IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               op_d    = dmop_norm(req_op);
               addr_d  = req_addr;
               wdata_d = req_wdata;
               rdata_d = '0;
               state_d = MAU_ISSUE;
`ifdef ALIGN_CHECK_EN
               err_d   = 1'b0;
               if (dmop_misaligned(req_op, req_addr[1:0])) begin
                  err_d   = 1'b1;
                  state_d = MAU_RESP;
               end
`endif
            end
         end
         MAU_ISSUE: begin
            if (bus_ready) begin
               state_d = write_q ? MAU_RESP : MAU_WAIT_R;
            end
         end
         MAU_WAIT_R: begin
            if (bus_rvalid) begin
               rdata_d = ext_data;
               state_d = MAU_RESP;
            end
         end
         default: state_d = MAU_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= MAU_IDLE;
         write_q <= 1'b0;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef ALIGN_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
`ifdef ALIGN_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   // Store narrowing: replicate the datum across all lanes and let byte enables pick.
   always_comb begin
      st_be    = 4'b1111;
      st_wdata = wdata_q;
      case (op_q)
         DMOP_BYTE, DMOP_BYTEU: begin
            st_be    = 4'b0001 << addr_q[1:0];
            st_wdata = {4{wdata_q[7:0]}};
         end
         DMOP_HALF, DMOP_HALFU: begin
            st_be    = addr_q[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{wdata_q[15:0]}};
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = wdata_q;
         end
      endcase
   end

   always_comb begin
      in_issue   = (state_q == MAU_ISSUE);
      req_ready  = (state_q == MAU_IDLE);
      resp_valid = (state_q == MAU_RESP);
      stall      = ((state_q != MAU_IDLE) && (state_q != MAU_RESP)) ||
                   ((state_q == MAU_IDLE) && req_valid);
      bus_valid  = in_issue;
      bus_we     = in_issue && write_q;
      bus_addr   = in_issue ? {addr_q[BUS_AW-1:2], 2'b00} : '0;
      bus_be     = in_issue ? st_be : 4'b0000;
      bus_wdata  = (in_issue && write_q) ? st_wdata : 32'h0;
      resp_rdata = resp_valid ? rdata_q : 32'h0;
`ifdef ALIGN_CHECK_EN
      resp_err   = resp_valid && err_q;
`else
      resp_err   = 1'b0;
`endif
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// loads/stores against an arithmetic reference model.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

`ifdef ALIGN_CHECK_EN
   localparam bit AlignEn = 1'b1;
`else
   localparam bit AlignEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_op;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err, stall;
   logic [31:0] resp_rdata;
   logic        bus_valid, bus_ready, bus_we, bus_rvalid;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.BUS_AW(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .stall      (stall),
      .bus_valid  (bus_valid),
      .bus_ready  (bus_ready),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_be     (bus_be),
      .bus_wdata  (bus_wdata),
      .bus_rvalid (bus_rvalid),
      .bus_rdata  (bus_rdata)
   );

   task automatic chk(input string tag, input string what, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s.%s observed=0x%08h expected=0x%08h", tag, what, obs, exp);
      end
   endtask

   // Reference: access size in bytes, lane offset, shift-and-mask extraction.
   function automatic void model(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rword,
                                 output logic [3:0] be, output logic [31:0] e_wd,
                                 output logic [31:0] e_rd, output logic mis);
      int          size;
      int          off;
      logic        sgn;
      logic [31:0] mask;
      logic [31:0] v;
      size = (op <= 3'd1) ? 1 : (op <= 3'd3) ? 2 : 4;
      sgn  = (op == 3'd0) || (op == 3'd2);
      mis  = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
      off  = (size == 1) ? int'(addr[1:0]) : (size == 2) ? int'(addr[1]) * 2 : 0;
      be   = 4'(((1 << size) - 1) << off);
      mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
      e_wd = (size == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
             (size == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
      v    = (rword >> (8 * off)) & mask;
      if (size < 4 && sgn && ((v & ((mask >> 1) + 32'd1)) != 0)) v = v | ~mask;
      e_rd = wr ? 32'h0 : v;
   endfunction

   task automatic run_access(input string tag, input logic wr, input logic [2:0] op,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rword, input int rdy, input int rv,
                             output logic [31:0] got);
      logic [3:0]  e_be;
      logic [31:0] e_wd, e_rd;
      logic        mis, errp, ev;
      int          lat;
      model(wr, op, addr, wd, rword, e_be, e_wd, e_rd, mis);
      errp = mis && AlignEn;
      if (errp) e_rd = 32'h0;
      lat = errp ? 1 : (wr ? 2 + rdy : 3 + rdy + rv);
      got = 32'h0;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = wr;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wd;
      bus_rdata = rword;
      for (int k = 0; k <= lat; k++) begin
         if (k > 0) @(negedge clk);
         ev         = !errp && k >= 1 && k <= 1 + rdy;
         bus_ready  = ev && (k == 1 + rdy);
         // Spurious rvalid while the request is still issuing must be ignored.
         bus_rvalid = ev ? 1'($urandom_range(0, 1)) : (!wr && !errp && k == 2 + rdy + rv);
         #1;
         chk(tag, "req_ready", req_ready, k == 0);
         chk(tag, "stall", stall, k != lat);
         chk(tag, "bus_valid", bus_valid, ev);
         chk(tag, "resp_valid", resp_valid, k == lat);
         if (ev) begin
            chk(tag, "bus_addr", bus_addr, {addr[31:2], 2'b00});
            chk(tag, "bus_we", bus_we, wr);
            if (wr) begin
               chk(tag, "bus_be", bus_be, e_be);
               chk(tag, "bus_wdata", bus_wdata, e_wd);
            end
         end
         if (k == lat) begin
            got = resp_rdata;
            chk(tag, "resp_rdata", resp_rdata, e_rd);
            chk(tag, "resp_err", resp_err, errp);
         end
      end
   endtask

   task automatic go_idle();
      @(negedge clk);
      req_valid  = 1'b0;
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] a;
      logic        w;
      logic [2:0]  op;

      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_op     = DMOP_WORD;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = 32'h0;
      #1;
      chk("reset", "req_ready", req_ready, 1);
      chk("reset", "bus_valid", bus_valid, 0);
      chk("reset", "stall", stall, 0);
      chk("reset", "resp_valid", resp_valid, 0);
      chk("reset", "resp_rdata", resp_rdata, 0);
      chk("reset", "resp_err", resp_err, 0);
      chk("reset", "bus_addr", bus_addr, 0);
      chk("reset", "bus_be", bus_be, 0);
      chk("reset", "bus_wdata", bus_wdata, 0);
      chk("reset", "bus_we", bus_we, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      run_access("sb", 1'b1, DMOP_BYTE, 32'h1003, 32'h0000_00A5, 32'h0, 0, 0, got);
      chk("sb", "rdata_zero", got, 32'h0);
      run_access("lh", 1'b0, DMOP_HALF, 32'h2002, 32'h0, 32'h8001_1234, 3, 2, got);
      chk("lh", "value", got, 32'hFFFF_8001);
      run_access("lhu", 1'b0, DMOP_HALFU, 32'h2002, 32'h0, 32'h8001_1234, 3, 2, got);
      chk("lhu", "value", got, 32'h0000_8001);
      run_access("lb", 1'b0, DMOP_BYTE, 32'h0, 32'h0, 32'h0000_007F, 0, 0, got);
      chk("lb", "value", got, 32'h0000_007F);
      run_access("lbu", 1'b0, DMOP_BYTEU, 32'h3, 32'h0, 32'hF000_0000, 0, 0, got);
      chk("lbu", "value", got, 32'h0000_00F0);
      run_access("sw", 1'b1, DMOP_WORD, 32'h3000, 32'hDEAD_BEEF, 32'h0, 1, 0, got);
      run_access("lw_b2b", 1'b0, DMOP_WORD, 32'h3000, 32'h0, 32'hDEAD_BEEF, 0, 0, got);
      chk("lw_b2b", "value", got, 32'hDEAD_BEEF);
      run_access("lw_unal", 1'b0, DMOP_WORD, 32'h1002, 32'h0, 32'h1122_3344, 0, 0, got);
      run_access("op_unk", 1'b0, 3'd7, 32'h1001, 32'h0, 32'hCAFE_F00D, 0, 1, got);
      go_idle();

      // Reset while waiting for read data; a late rvalid must not retire anything.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_op = DMOP_WORD; req_addr = 32'h40;
      @(negedge clk);
      bus_ready = 1'b1;
      @(negedge clk);
      bus_ready = 1'b0;
      req_valid = 1'b0;
      #1;
      chk("rst_mid", "in_wait_bus_valid", bus_valid, 0);
      chk("rst_mid", "in_wait_stall", stall, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_mid", "req_ready", req_ready, 1);
      chk("rst_mid", "stall", stall, 0);
      chk("rst_mid", "bus_valid", bus_valid, 0);
      @(negedge clk);
      reset_n = 1'b1;
      bus_rvalid = 1'b1;
      bus_rdata  = 32'h1234_5678;
      #1;
      chk("rst_mid", "late_rvalid_resp", resp_valid, 0);
      @(negedge clk);
      bus_rvalid = 1'b0;
      #1;
      chk("rst_mid", "after_resp", resp_valid, 0);
      chk("rst_mid", "after_ready", req_ready, 1);

      for (int i = 0; i < 150; i++) begin
         a  = $urandom();
         w  = 1'($urandom_range(0, 1));
         op = 3'($urandom_range(0, 7));
         run_access("rand", w, op, a, $urandom(), $urandom(), $urandom_range(0, 3),
                    $urandom_range(0, 3), got);
         if ($urandom_range(0, 3) == 0) go_idle();
      end
      go_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
